// File: rtl/r_enc_gen.sv
// ---------------------------------------------------------------------------
// r_enc_gen : quadrature rotary-encoder generator (transmit side of A/B link)
//
// Accepts one detent step per valid/ready handshake and plays out one full
// quadrature cycle on r_A/r_B, so that a decoder watching the lines reports
// exactly one event in the commanded direction. A detent position counter
// tracks the net number of steps issued.
//
// Parameters
//   PHASE_CYCLES : clocks each quadrature phase is held (>=1, >=3 with bounce)
//   POS_W        : width of the detent position counter
//
// Ports
//   clk        in   system clock, everything on posedge
//   rst        in   synchronous active-high reset
//   step_valid in   step request
//   step_left  in   direction of the request (1 = left, 0 = right)
//   step_ready out  generator can accept a step
//   r_A        out  quadrature channel A
//   r_B        out  quadrature channel B
//   busy       out  a step is in progress
//   done       out  one-cycle pulse when a step completes
//   pos        out  detent position counter (wraps modulo 2^POS_W)
//
// Optional feature
//   RENC_GEN_BOUNCE_EN : when defined, the line that changes at the start of
//   each phase shows new/old/new... values to emulate contact bounce.
// ---------------------------------------------------------------------------
module r_enc_gen #(
    parameter int PHASE_CYCLES = 4,
    parameter int POS_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_valid,
    input  logic             step_left,
    output logic             step_ready,
    output logic             r_A,
    output logic             r_B,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        PH3,
        PH4
    } StateE;

    localparam int            TW         = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PHASE_CYCLES - 1);

    // A bad phase length cannot be fixed at run time, so refuse to elaborate.
    generate
`ifdef RENC_GEN_BOUNCE_EN
        if (PHASE_CYCLES < 3) begin : g_badPhaseCycles
            $error("r_enc_gen: PHASE_CYCLES must be >= 3 when contact bounce is enabled");
        end
`else
        if (PHASE_CYCLES < 1) begin : g_badPhaseCycles
            $error("r_enc_gen: PHASE_CYCLES must be >= 1");
        end
`endif
    endgenerate

    StateE            r_state;
    logic [TW-1:0]    r_timer;
    logic             r_dir;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [POS_W-1:0] r_pos;

    StateE            w_nextState;
    logic [TW-1:0]    w_nextTimer;
    logic             w_nextDir;
    logic             w_nextDone;
    logic [POS_W-1:0] w_nextPos;
    logic [1:0]       w_nextLines;
    logic             w_handshake;
    logic             w_phaseEnd;

    // {B,A} pattern for a phase. The left sequence is the right sequence with
    // the two channels swapped, which is what makes B lead A for left steps.
    function automatic logic [1:0] phaseLines(input StateE s, input logic dir);
        logic [1:0] rightLines;
        case (s)
            PH1:     rightLines = 2'b01;
            PH2:     rightLines = 2'b11;
            PH3:     rightLines = 2'b10;
            default: rightLines = 2'b00;
        endcase
        return dir ? {rightLines[0], rightLines[1]} : rightLines;
    endfunction

`ifdef RENC_GEN_BOUNCE_EN
    // The phase preceding s; its pattern differs from s in exactly one line,
    // so showing it for one cycle makes just the changing line bounce.
    function automatic StateE prevPhase(input StateE s);
        case (s)
            PH2:     return PH1;
            PH3:     return PH2;
            PH4:     return PH3;
            default: return IDLE;
        endcase
    endfunction
`endif

    assign w_handshake = step_valid & r_ready;
    assign w_phaseEnd  = (r_timer == TIMER_LAST);

    // Next-state logic. Every output is registered from the next state, so
    // the first line change lands on the same edge as the handshake.
    always_comb begin
        w_nextState = r_state;
        w_nextTimer = r_timer;
        w_nextDir   = r_dir;
        w_nextDone  = 1'b0;
        w_nextPos   = r_pos;
        w_nextLines = 2'b00;

        case (r_state)
            IDLE: begin
                w_nextTimer = '0;
                if (w_handshake) begin
                    w_nextState = PH1;
                    w_nextDir   = step_left;
                end
            end
            PH1, PH2, PH3: begin
                if (w_phaseEnd) begin
                    w_nextTimer = '0;
                    case (r_state)
                        PH1:     w_nextState = PH2;
                        PH2:     w_nextState = PH3;
                        default: w_nextState = PH4;
                    endcase
                end else begin
                    w_nextTimer = r_timer + TW'(1);
                end
            end
            PH4: begin
                if (w_phaseEnd) begin
                    w_nextTimer = '0;
                    w_nextState = IDLE;
                    w_nextDone  = 1'b1;
                    w_nextPos   = r_dir ? (r_pos - POS_W'(1)) : (r_pos + POS_W'(1));
                end else begin
                    w_nextTimer = r_timer + TW'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextTimer = '0;
            end
        endcase

        w_nextLines = phaseLines(w_nextState, w_nextDir);
`ifdef RENC_GEN_BOUNCE_EN
        if ((w_nextState != IDLE) && (w_nextTimer == TW'(1))) begin
            w_nextLines = phaseLines(prevPhase(w_nextState), w_nextDir);
        end
`endif
    end

    // State and output registers; reset abandons any step in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_dir   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pos   <= '0;
            r_A     <= 1'b0;
            r_B     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_timer <= w_nextTimer;
            r_dir   <= w_nextDir;
            r_ready <= (w_nextState == IDLE);
            r_busy  <= (w_nextState != IDLE);
            r_done  <= w_nextDone;
            r_pos   <= w_nextPos;
            r_A     <= w_nextLines[0];
            r_B     <= w_nextLines[1];
        end
    end

    assign step_ready = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pos        = r_pos;

endmodule

// File: tb/tb_r_enc_gen.sv
// ---------------------------------------------------------------------------
// tb_r_enc_gen : self-checking bench for r_enc_gen
//
// Drives directed and randomized step commands, predicts the A/B waveform,
// handshake signals, done pulse and position from the behavioural rules, and
// runs an independent quadrature decoder on the lines to count events.
// ---------------------------------------------------------------------------
module tb_r_enc_gen;

    localparam int PC    = 4;
    localparam int POS_W = 8;
    localparam int STEP  = 4 * PC;

    logic             clk;
    logic             rst;
    logic             step_valid;
    logic             step_left;
    logic             step_ready;
    logic             r_A;
    logic             r_B;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] pos;

    int nChecks   = 0;
    int nFails    = 0;
    int modelPos  = 0;
    int expRight  = 0;
    int expLeft   = 0;
    int cyc       = 0;
    int lastHs    = 0;

    int decAccum  = 0;
    int decRight  = 0;
    int decLeft   = 0;
    int decIllegal = 0;
    logic [1:0] decPrev = 2'b00;

    r_enc_gen #(
        .PHASE_CYCLES(PC),
        .POS_W       (POS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_valid(step_valid),
        .step_left (step_left),
        .step_ready(step_ready),
        .r_A       (r_A),
        .r_B       (r_B),
        .busy      (busy),
        .done      (done),
        .pos       (pos)
    );

    // Free-running clock and a cycle counter used to measure step periods.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Position of a {B,A} code along the right-turning Gray sequence.
    function automatic int grayIdx(input logic [1:0] ba);
        case (ba)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int quadDelta(input logic [1:0] prev, input logic [1:0] cur);
        int d;
        d = (grayIdx(cur) - grayIdx(prev) + 4) % 4;
        if (d == 1) return 1;
        if (d == 3) return -1;
        return 0;
    endfunction

    // Independent quadrature decoder: accumulates +/-1 per Gray transition and
    // reports an event whenever the lines settle at 00 after a full cycle.
    always @(posedge clk) begin
        if (rst) begin
            decAccum <= 0;
            decPrev  <= {r_B, r_A};
        end else begin
            decPrev <= {r_B, r_A};
            if ((grayIdx({r_B, r_A}) - grayIdx(decPrev) + 4) % 4 == 2)
                decIllegal <= decIllegal + 1;
            if ({r_B, r_A} == 2'b00 && decAccum + quadDelta(decPrev, {r_B, r_A}) == 4) begin
                decRight <= decRight + 1;
                decAccum <= 0;
            end else if ({r_B, r_A} == 2'b00 && decAccum + quadDelta(decPrev, {r_B, r_A}) == -4) begin
                decLeft  <= decLeft + 1;
                decAccum <= 0;
            end else begin
                decAccum <= decAccum + quadDelta(decPrev, {r_B, r_A});
            end
        end
    end

    // Expected {B,A} at cycle k (0-based) of a step, from the phase table.
    function automatic logic [1:0] expLines(input logic dir, input int k);
        logic [1:0] tbl [4];
        logic [1:0] v;
        int ph;
        tbl[0] = 2'b01;
        tbl[1] = 2'b11;
        tbl[2] = 2'b10;
        tbl[3] = 2'b00;
        ph = k / PC;
        v  = tbl[ph];
`ifdef RENC_GEN_BOUNCE_EN
        if (k % PC == 1) v = (ph == 0) ? 2'b00 : tbl[ph-1];
`endif
        return dir ? {v[0], v[1]} : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Idle cycles with no request: lines at rest, ready, no done pulse.
    task automatic idleCycles(input int n);
        step_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            step_left = 1'($urandom % 2);
            @(posedge clk); #1;
            checkOutput("idle_lines", {30'd0, r_B, r_A}, 32'd0);
            checkOutput("idle_ready", {31'd0, step_ready}, 32'd1);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("idle_done", {31'd0, done}, 32'd0);
        end
    endtask

    // One step: handshake, check every cycle of the waveform, then check the
    // completion cycle. With holdValid the request stays asserted throughout,
    // so any acceptance while busy would corrupt the waveform.
    task automatic applyStimulus(input logic dir, input bit holdValid, input bit checkPeriod);
        checkOutput("ready_before_step", {31'd0, step_ready}, 32'd1);
        step_valid = 1'b1;
        step_left  = dir;
        @(posedge clk); #1;
        if (checkPeriod) checkOutput("step_period", cyc - lastHs, 32'd17);
        lastHs = cyc;
        if (!holdValid) step_valid = 1'b0;
        for (int k = 0; k < STEP; k++) begin
            checkOutput("step_lines", {30'd0, r_B, r_A}, {30'd0, expLines(dir, k)});
            checkOutput("step_busy", {31'd0, busy}, 32'd1);
            checkOutput("step_ready", {31'd0, step_ready}, 32'd0);
            checkOutput("step_done", {31'd0, done}, 32'd0);
            step_left = 1'($urandom % 2);
            if (!holdValid) step_valid = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        if (!holdValid) step_valid = 1'b0;
        modelPos = (modelPos + (dir ? -1 : 1)) & ((1 << POS_W) - 1);
        if (dir) expLeft++; else expRight++;
        checkOutput("done_pulse", {31'd0, done}, 32'd1);
        checkOutput("done_lines", {30'd0, r_B, r_A}, 32'd0);
        checkOutput("done_busy", {31'd0, busy}, 32'd0);
        checkOutput("done_ready", {31'd0, step_ready}, 32'd1);
        checkOutput("done_pos", {24'd0, pos}, modelPos);
        checkOutput("dec_right", decRight, expRight);
        checkOutput("dec_left", decLeft, expLeft);
    endtask

    initial begin
        rst        = 1'b1;
        step_valid = 1'b0;
        step_left  = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_lines", {30'd0, r_B, r_A}, 32'd0);
        checkOutput("rst_ready", {31'd0, step_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_pos", {24'd0, pos}, 32'd0);
        rst = 1'b0;
        idleCycles(2);

        // Left from 0 wraps to all-ones, then right wraps back to 0.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("wrap_left_pos", {24'd0, pos}, 32'hFF);
        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("wrap_right_pos", {24'd0, pos}, 32'h00);
        idleCycles(1);

        // Back-to-back steps with the request held high, alternating direction.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("b2b_pos", {24'd0, pos}, 32'h00);
        idleCycles(1);

        // Randomized directions and idle gaps.
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'($urandom % 2), 1'b0, 1'b0);
            idleCycles(1 + int'($urandom % 3));
        end

        // Make pos nonzero, then reset in the middle of a right step.
        applyStimulus(1'b0, 1'b0, 1'b0);
        idleCycles(1);
        step_valid = 1'b1;
        step_left  = 1'b0;
        @(posedge clk); #1;
        step_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_lines", {30'd0, r_B, r_A}, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_pos", {24'd0, pos}, 32'd0);
        checkOutput("midrst_ready", {31'd0, step_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        modelPos = 0;
        idleCycles(STEP + 2);

        // One more step after the abandoned one, then decoder-level summary.
        applyStimulus(1'b1, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("dec_illegal", decIllegal, 32'd0);
        checkOutput("dec_right_final", decRight, expRight);
        checkOutput("dec_left_final", decLeft, expLeft);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/r_enc_gen.md
Name: r_enc_gen

Overview:
- Quadrature rotary-encoder generator: the transmit side of the rotary-encoder A/B interface.
- Accepts one detent step command per handshake, with a direction, and drives a full A/B quadrature cycle on r_A/r_B.
- A decoder watching r_A/r_B reports exactly one event with the commanded direction.
- Used as encoder emulation for loopback tests and for driving downstream encoder inputs from logic.

Parameters:
- PHASE_CYCLES, 4: clocks each quadrature phase is held. Minimum 1; minimum 3 when BOUNCE_EN is defined.
- POS_W, 8: width of the position counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- step_valid  input  1  step request.
- step_left  input  1  direction of the request: 1 = left, 0 = right. Sampled only on handshake.
- step_ready  output  1  generator can accept a step.
- r_A  output  1  quadrature channel A.
- r_B  output  1  quadrature channel B.
- busy  output  1  a step is in progress.
- done  output  1  one-cycle pulse when a step completes.
- pos  output  POS_W  detent position counter.

Behaviour:
- All outputs are registered. Below, {B,A} means {r_B,r_A}.
- Reset (rst=1 at posedge): state=IDLE, timer=0, {B,A}=00, busy=0, done=0, pos=0. step_ready is 0 while rst is high.
- Reset mid-step: the step is abandoned, no done pulse, pos cleared, lines return to 00 on that edge.
- States: IDLE, PH1, PH2, PH3, PH4.
- IDLE:
  - {B,A}=00, step_ready=1, busy=0.
  - Handshake = step_valid & step_ready at a posedge. On handshake, latch step_left into dir, go to PH1, timer=0.
- Phase outputs:
  - Right (dir=0): PH1=01, PH2=11, PH3=10, PH4=00.
  - Left (dir=1): PH1=10, PH2=11, PH3=01, PH4=00.
  - B leads for left, A leads for right.
- Phase timing:
  - Each PHx lasts exactly PHASE_CYCLES clocks. timer counts 0..PHASE_CYCLES-1, then advances the state and clears.
  - step_ready=0 and busy=1 in PH1..PH4.
- Latency: the first changed line appears on the edge of the handshake. The step occupies 4*PHASE_CYCLES cycles.
- Completion: on the edge leaving PH4:
  - state=IDLE and done=1 for exactly one cycle.
  - pos updates on the same edge: pos+1 for right, pos-1 for left, modulo 2^POS_W (0 -> 2^POS_W-1 on left, max -> 0 on right).
- Back-to-back steps: a new handshake is possible in the first IDLE cycle (the cycle done is high). The minimum step-to-step period is 4*PHASE_CYCLES+1 clocks.
- step_valid while not ready: ignored, not queued. step_left changes outside the handshake have no effect.
- Exactly one of r_A/r_B changes per phase transition. Both never change on the same edge.

Optional Feature:
- Macro RENC_GEN_BOUNCE_EN.
- Defined: at the start of each phase, the one line that changes emulates contact bounce:
  - cycle 0 of the phase: new value;
  - cycle 1: old value;
  - cycles 2..PHASE_CYCLES-1: new value.
  - The other line is stable throughout.
  - PHASE_CYCLES<3 is a configuration error, flagged by an elaboration-time check.
  - Phase durations, done and pos timing are unchanged.
- Not defined: lines switch cleanly once per phase, as specified above.

Test Plan:
- Reset then idle, rst high 3 cycles -> {B,A}=00, step_ready=1 after release, busy=0, done=0, pos=0.
- PHASE_CYCLES=4, right step at edge T -> {B,A}=01 for T..T+3, 11 for T+4..T+7, 10 for T+8..T+11, 00 from T+12. done=1 for one cycle after edge T+16; pos 0->1.
- Left step from pos=0 -> sequence 10,11,01,00 at 4 cycles each. pos=2^POS_W-1 (8'hFF). Attached decoder reports one event with left=1.
- step_valid held high with alternating step_left -> new step accepted in the done cycle. Period exactly 17 clocks. pos returns to 0 after right, left. Requests while busy are not accepted.
- rst asserted at cycle 6 of a right step -> lines 00 next edge, no done, pos=0, step_ready=1 after release.
- RENC_GEN_BOUNCE_EN defined, right step -> A pattern 1,0,1,1 in PH1 and B pattern 1,0,1,1 in PH2. Decoder still reports exactly one right event.
